// File: rtl/cls_pkg.sv
// cls_pkg: shared FSM state encoding and ASCII constants for the CLS display path
package cls_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;
  localparam logic [7:0] ESC   = 8'h1B;
  localparam logic [7:0] NUL   = 8'h00;
  localparam logic [7:0] SPACE = 8'h20;
endpackage

// File: rtl/cls_spi_tx_spi_clk_gen.sv
// spi_clk_gen: mode-0 SCLK divider with edge strobes that mark the cycle sclk toggles
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div;
  logic tc;
  assign tc = en && div == DW'(CLK_DIV - 1);
  assign rise_pulse = tc && !sclk;
  assign fall_pulse = tc && sclk;
  // half-period counter; disabling parks sclk low and restarts the low half
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (tc) begin
      div  <= '0;
      sclk <= ~sclk;
    end else
      div <= div + 1'b1;
endmodule

// File: rtl/cls_spi_tx.sv
// cls_spi_tx: serialises the packed display frame to the LCD over SPI mode 0; CLS_SPI_NULL_TERM_EN ends the frame at the first 8'h00 byte
module cls_spi_tx
  import cls_pkg::*;
#(
  parameter int DATA_W    = 152,
  parameter int CLK_DIV   = 4,
  parameter int GAP_CYC   = 16,
  parameter int SETUP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              begin_transmission,
  input  logic [DATA_W-1:0] data_in,
  output logic              end_transmission,
  output logic              busy,
  output logic              ss_n,
  output logic              sclk,
  output logic              mosi
);
  localparam int NB  = DATA_W / 8;
  localparam int BCW = $clog2(NB + 1);
  localparam int CMX = GAP_CYC > SETUP_CYC ? GAP_CYC : SETUP_CYC;
  localparam int CW  = $clog2(CMX + 1);
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic [BCW-1:0]    byte_cnt;
  logic [2:0]        bit_cnt;
  logic              rise_pulse, fall_pulse, skip;
`ifdef CLS_SPI_NULL_TERM_EN
  assign skip = shreg[DATA_W-1 -: 8] == NUL;
`else
  assign skip = 1'b0;
`endif
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == ST_SHIFT),
    .sclk      (sclk),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );
  // frame sequencer: byte shifting, inter-byte gaps, select setup/hold and the done handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= ST_IDLE;
      shreg            <= '0;
      cnt              <= '0;
      byte_cnt         <= '0;
      bit_cnt          <= '0;
      ss_n             <= 1'b1;
      mosi             <= 1'b0;
      busy             <= 1'b0;
      end_transmission <= 1'b0;
    end else
      case (state)
        ST_IDLE:
          if (begin_transmission) begin
            shreg    <= data_in;
            mosi     <= data_in[DATA_W-1];
            byte_cnt <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            ss_n     <= 1'b0;
            state    <= ST_SETUP;
          end
        ST_SETUP:
          if (cnt == CW'(SETUP_CYC - 1)) begin
            cnt   <= '0;
            state <= skip ? ST_HOLD : ST_SHIFT;
          end else
            cnt <= cnt + 1'b1;
        ST_SHIFT: begin
          if (rise_pulse) bit_cnt <= bit_cnt + 1'b1;
          if (fall_pulse) begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            mosi  <= shreg[DATA_W-2];
            if (bit_cnt == 3'd0) begin
              byte_cnt <= byte_cnt + 1'b1;
              state    <= byte_cnt == BCW'(NB - 1) ? ST_HOLD : ST_GAP;
            end
          end
        end
        ST_GAP:
          if (cnt == CW'(GAP_CYC - 1)) begin
            cnt   <= '0;
            mosi  <= shreg[DATA_W-1];
            state <= skip ? ST_HOLD : ST_SHIFT;
          end else
            cnt <= cnt + 1'b1;
        ST_HOLD:
          if (cnt == CW'(SETUP_CYC - 1)) begin
            cnt              <= '0;
            ss_n             <= 1'b1;
            end_transmission <= 1'b1;
            state            <= ST_DONE;
          end else
            cnt <= cnt + 1'b1;
        ST_DONE: begin
          end_transmission <= 1'b0;
          busy             <= 1'b0;
          state            <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_cls_spi_tx.sv
// tb_cls_spi_tx: directed checks of framing, SPI timing, start filtering, reset abort and back-to-back frames
module tb_cls_spi_tx;
  localparam int DATA_W = 152;
`ifdef CLS_SPI_NULL_TERM_EN
  localparam int NEXP = 18;
`else
  localparam int NEXP = 19;
`endif
  logic clk, rst_n, begin_tx, end_tx, busy, ss_n, sclk, mosi;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] frame;
  int checks = 0, errors = 0;
  int rises = 0, nb = 0, ends = 0, ssn_bad = 0, bp = 0;
  int rb, nbb, eb;
  logic [7:0] sh;
  logic [7:0] rx [256];
  time rt [2048];
  time sf, sr;

  cls_spi_tx #(.DATA_W(DATA_W), .CLK_DIV(2), .GAP_CYC(4), .SETUP_CYC(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .begin_transmission(begin_tx),
    .data_in           (data_in),
    .end_transmission  (end_tx),
    .busy              (busy),
    .ss_n              (ss_n),
    .sclk              (sclk),
    .mosi              (mosi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge sclk or posedge ss_n)
    if (ss_n) bp = 0;
    else begin
      sh = {sh[6:0], mosi};
      if (rises < 2048) rt[rises] = $time;
      rises++;
      if (bp == 7) begin
        if (nb < 256) rx[nb] = sh;
        nb++;
        bp = 0;
      end else bp++;
    end

  always @(posedge sclk) if (ss_n !== 1'b0) ssn_bad++;
  always @(posedge clk) if (end_tx === 1'b1) ends++;
  always @(negedge ss_n) sf = $time;
  always @(posedge ss_n) sr = $time;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_end(input string tag);
    for (int i = 0; i < 3000 && end_tx !== 1'b1; i++) @(negedge clk);
    chk(tag, {31'd0, end_tx}, 32'd1);
  endtask

  task automatic start_frame();
    rb = rises; nbb = nb; eb = ends;
    data_in = frame;
    @(negedge clk) begin_tx = 1'b1;
    @(negedge clk) begin_tx = 1'b0;
    data_in = {19{8'hA5}};
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_rises"}, rises - rb, NEXP * 8);
    chk({tag, "_ends"}, ends - eb, 1);
    for (int i = 0; i < NEXP; i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, rx[nbb + i]}, {24'd0, frame[DATA_W-1-8*i -: 8]});
  endtask

  initial begin
    frame = {8'h1B, 8'h5B, 8'h6A, 8'h31, 8'h32, 8'h33, 8'h34, {11{8'h20}}, 8'h00};
    data_in = frame;
    begin_tx = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", {31'd0, ss_n}, 1);
    chk("rst_sclk", {31'd0, sclk}, 0);
    chk("rst_mosi", {31'd0, mosi}, 0);
    chk("rst_end", {31'd0, end_tx}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_frame();
    chk("a_busy_mid", {31'd0, busy}, 1);
    chk("a_ss_low", {31'd0, ss_n}, 0);
    wait_end("a_timeout");
    chk("a_busy_done", {31'd0, busy}, 1);
    @(negedge clk);
    chk("a_busy_idle", {31'd0, busy}, 0);
    check_frame("a");
    chk("a_first_bits", {24'd0, rx[nbb]}, 32'h1B);
    chk("a_ssn_to_rise", 32'((rt[rb] - sf) / 10), 4);
    chk("a_rise1_rise8", 32'((rt[rb + 7] - rt[rb]) / 10), 28);
    chk("a_byte_plus_gap", 32'((rt[rb + 8] - rt[rb]) / 10), 36);
    chk("a_lastrise_ssn", 32'((sr - rt[rises - 1]) / 10), 4);
    chk("a_ssn_bad", ssn_bad, 0);
`ifdef CLS_SPI_NULL_TERM_EN
    chk("a_last_byte", {24'd0, rx[nb - 1]}, 32'h20);
`else
    chk("a_last_byte", {24'd0, rx[nb - 1]}, 32'h00);
`endif

    rb = rises; nbb = nb; eb = ends;
    data_in = frame;
    @(negedge clk) begin_tx = 1'b1;
    repeat (500) @(negedge clk);
    begin_tx = 1'b0;
    repeat (50) @(negedge clk);
    chk("h_busy_mid", {31'd0, busy}, 1);
    begin_tx = 1'b1;
    @(negedge clk) begin_tx = 1'b0;
    wait_end("h_timeout");
    @(negedge clk);
    check_frame("h");
    repeat (20) @(negedge clk);
    chk("h_no_restart", rises - rb, NEXP * 8);
    chk("h_idle_busy", {31'd0, busy}, 0);

    start_frame();
    for (int i = 0; i < 2000 && rises - rb < 43; i++) @(negedge clk);
    chk("r_reached_byte5", {31'd0, rises - rb >= 43}, 1);
    rst_n = 1'b0;
    #1;
    chk("r_ss_n", {31'd0, ss_n}, 1);
    chk("r_sclk", {31'd0, sclk}, 0);
    chk("r_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    chk("r_no_end", ends - eb, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_frame();
    wait_end("r2_timeout");
    @(negedge clk);
    check_frame("r2");

    start_frame();
    wait_end("b1_timeout");
    @(negedge clk);
    chk("b1_busy_gap", {31'd0, busy}, 0);
    chk("b1_rises", rises - rb, NEXP * 8);
    rb = rises; nbb = nb; eb = ends;
    data_in = frame;
    begin_tx = 1'b1;
    @(negedge clk) begin_tx = 1'b0;
    chk("b2_busy_accept", {31'd0, busy}, 1);
    data_in = {19{8'h5A}};
    wait_end("b2_timeout");
    @(negedge clk);
    check_frame("b2");
    chk("final_ssn_bad", ssn_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
